// File: rtl/frame_mem_scheduler.sv
// Burst scheduler sharing one frame-memory command port between the pixel writer and the
// frame reader, with round-robin burst arbitration and triple-buffer rotation at frame end.
module frame_mem_scheduler #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned FRAME_WORDS = 921600,
  parameter int unsigned BURST_LEN   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        wr_req_i,
  input  logic        rd_req_i,
  output logic        wr_grant_o,
  output logic        rd_grant_o,
  output logic        mem_cmd_valid_o,
  input  logic        mem_cmd_ready_i,
  output logic        mem_cmd_we_o,
  output logic [31:0] mem_cmd_addr_o,
  input  logic        mem_done_i,
  output logic [1:0]  write_idx_o,
  output logic [1:0]  read_idx_o,
  output logic        frame_swap_o,
  output logic        busy_o
);

  localparam int unsigned      CNT_W       = $clog2(FRAME_WORDS + 1);
  localparam logic [31:0]      FRAME_BYTES = 32'(FRAME_WORDS * 4);
  localparam logic [CNT_W-1:0] FRAME_CNT   = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] BURST_INC   = CNT_W'(BURST_LEN);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SWAP  = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [CNT_W-1:0] rd_cnt_q;
  logic [1:0]       write_idx_q;
  logic [1:0]       read_idx_q;
  logic             prio_wr_q;
  logic             sel_wr_q;
  logic             valid_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic             wr_grant_q;
  logic             rd_grant_q;
  logic             frame_swap_q;
  logic             busy_q;

  logic             wr_elig_d;
  logic             rd_elig_d;
  logic             pick_any_d;
  logic             pick_wr_d;
  logic [31:0]      cmd_addr_d;
  logic [CNT_W-1:0] wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_d;

  // Arbitration choice, candidate burst address and post-burst counter values.
  always_comb begin
    wr_elig_d  = wr_req_i && (wr_cnt_q < FRAME_CNT);
    rd_elig_d  = rd_req_i && (rd_cnt_q < FRAME_CNT);
    pick_any_d = wr_elig_d || rd_elig_d;
    if (wr_elig_d && rd_elig_d) begin
      pick_wr_d = prio_wr_q;
    end else begin
      pick_wr_d = wr_elig_d;
    end
    if (pick_wr_d) begin
      cmd_addr_d = BASE_ADDR + (32'(write_idx_q) * FRAME_BYTES) + (32'(wr_cnt_q) << 32'd2);
    end else begin
      cmd_addr_d = BASE_ADDR + (32'(read_idx_q) * FRAME_BYTES) + (32'(rd_cnt_q) << 32'd2);
    end
    if (sel_wr_q) begin
      wr_cnt_d = wr_cnt_q + BURST_INC;
      rd_cnt_d = rd_cnt_q;
    end else begin
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q + BURST_INC;
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      write_idx_q  <= 2'd0;
      read_idx_q   <= 2'd2;
      prio_wr_q    <= 1'b1;
      sel_wr_q     <= 1'b0;
      valid_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wr_grant_q   <= 1'b0;
      rd_grant_q   <= 1'b0;
      frame_swap_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wr_grant_q   <= 1'b0;
      rd_grant_q   <= 1'b0;
      frame_swap_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_ARB;
            busy_q  <= 1'b1;
          end
        end
        ST_ARB: begin
          if (pick_any_d) begin
            sel_wr_q <= pick_wr_d;
            we_q     <= pick_wr_d;
            addr_q   <= cmd_addr_d;
            valid_q  <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_cmd_ready_i) begin
            valid_q    <= 1'b0;
            wr_grant_q <= sel_wr_q;
            rd_grant_q <= ~sel_wr_q;
            prio_wr_q  <= ~sel_wr_q;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_done_i) begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            if ((wr_cnt_d == FRAME_CNT) && (rd_cnt_d == FRAME_CNT)) begin
              // Both streams finished the frame: rotate buffers and restart counts.
              state_q      <= ST_SWAP;
              frame_swap_q <= 1'b1;
              write_idx_q  <= (write_idx_q == 2'd2) ? 2'd0 : write_idx_q + 2'd1;
              read_idx_q   <= (read_idx_q == 2'd2) ? 2'd0 : read_idx_q + 2'd1;
              wr_cnt_q     <= '0;
              rd_cnt_q     <= '0;
            end else begin
              state_q <= ST_ARB;
            end
          end
        end
        ST_SWAP: begin
          state_q <= ST_ARB;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_grant_o      = wr_grant_q;
  assign rd_grant_o      = rd_grant_q;
  assign mem_cmd_valid_o = valid_q;
  assign mem_cmd_we_o    = we_q;
  assign mem_cmd_addr_o  = addr_q;
  assign write_idx_o     = write_idx_q;
  assign read_idx_o      = read_idx_q;
  assign frame_swap_o    = frame_swap_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_frame_mem_scheduler.sv
// Directed bench for frame_mem_scheduler with a 64-word frame and 16-word bursts.
module tb_frame_mem_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        wr_req;
  logic        rd_req;
  logic        mem_cmd_ready;
  logic        mem_done;
  logic        wr_grant;
  logic        rd_grant;
  logic        mem_cmd_valid;
  logic        mem_cmd_we;
  logic [31:0] mem_cmd_addr;
  logic [1:0]  write_idx;
  logic [1:0]  read_idx;
  logic        frame_swap;
  logic        busy;

  int checks = 0;
  int passed = 0;

  frame_mem_scheduler #(
    .BASE_ADDR  (32'h0000_0000),
    .FRAME_WORDS(64),
    .BURST_LEN  (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .wr_req_i       (wr_req),
    .rd_req_i       (rd_req),
    .wr_grant_o     (wr_grant),
    .rd_grant_o     (rd_grant),
    .mem_cmd_valid_o(mem_cmd_valid),
    .mem_cmd_ready_i(mem_cmd_ready),
    .mem_cmd_we_o   (mem_cmd_we),
    .mem_cmd_addr_o (mem_cmd_addr),
    .mem_done_i     (mem_done),
    .write_idx_o    (write_idx),
    .read_idx_o     (read_idx),
    .frame_swap_o   (frame_swap),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (mem_cmd_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(mem_cmd_valid), 32'd1);
  endtask

  // One complete burst: command check, handshake, grant, completion, swap flag.
  task automatic burst(input string tag, input logic we, input logic [31:0] addr, input logic swap);
    wait_valid(tag);
    chk({tag, "_we"}, 32'(mem_cmd_we), 32'(we));
    chk({tag, "_addr"}, mem_cmd_addr, addr);
    mem_cmd_ready = 1'b1;
    tick();
    chk({tag, "_wgnt"}, 32'(wr_grant), 32'(we));
    chk({tag, "_rgnt"}, 32'(rd_grant), 32'(!we));
    chk({tag, "_vdrop"}, 32'(mem_cmd_valid), 32'd0);
    mem_cmd_ready = 1'b0;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk({tag, "_swap"}, 32'(frame_swap), 32'(swap));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [1:0] widx_tab [0:3];
  logic [1:0] ridx_tab [0:3];

  initial begin
    widx_tab[0] = 2'd0; widx_tab[1] = 2'd1; widx_tab[2] = 2'd2; widx_tab[3] = 2'd0;
    ridx_tab[0] = 2'd2; ridx_tab[1] = 2'd0; ridx_tab[2] = 2'd1; ridx_tab[3] = 2'd2;
    rst = 1'b1; start = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    mem_cmd_ready = 1'b0; mem_done = 1'b0;
    do_reset();

    // Reset values
    chk("rst_valid", 32'(mem_cmd_valid), 32'd0);
    chk("rst_we", 32'(mem_cmd_we), 32'd0);
    chk("rst_addr", mem_cmd_addr, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_widx", 32'(write_idx), 32'd0);
    chk("rst_ridx", 32'(read_idx), 32'd2);
    chk("rst_swap", 32'(frame_swap), 32'd0);

    // Writer alone: four writes, then masked until the reader finishes
    wr_req = 1'b1;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    burst("t1_w0", 1'b1, 32'h000, 1'b0);
    burst("t1_w1", 1'b1, 32'h040, 1'b0);
    burst("t1_w2", 1'b1, 32'h080, 1'b0);
    burst("t1_w3", 1'b1, 32'h0C0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_masked", 32'(mem_cmd_valid), 32'd0);
    end
    chk("t5_widx", 32'(write_idx), 32'd0);
    rd_req = 1'b1;
    burst("t5_r0", 1'b0, 32'h200, 1'b0);
    burst("t5_r1", 1'b0, 32'h240, 1'b0);
    burst("t5_r2", 1'b0, 32'h280, 1'b0);
    burst("t5_r3", 1'b0, 32'h2C0, 1'b1);
    chk("t5_widx_after", 32'(write_idx), 32'd1);
    chk("t5_ridx_after", 32'(read_idx), 32'd0);

    // Both streams, three full frames from a fresh reset
    do_reset();
    chk("t2_rst_widx", 32'(write_idx), 32'd0);
    wr_req = 1'b1;
    rd_req = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 4; b++) begin
        burst("t3_w", 1'b1, 32'(widx_tab[f]) * 32'h100 + 32'(b) * 32'h40, 1'b0);
        burst("t3_r", 1'b0, 32'(ridx_tab[f]) * 32'h100 + 32'(b) * 32'h40, b == 3);
      end
      chk("t3_widx", 32'(write_idx), 32'(widx_tab[f + 1]));
      chk("t3_ridx", 32'(read_idx), 32'(ridx_tab[f + 1]));
    end

    // Ready held low in ISSUE: command stable, no grant
    wait_valid("t4");
    chk("t4_addr0", mem_cmd_addr, 32'h000);
    chk("t4_we0", 32'(mem_cmd_we), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", 32'(mem_cmd_valid), 32'd1);
      chk("t4_hold_addr", mem_cmd_addr, 32'h000);
      chk("t4_hold_we", 32'(mem_cmd_we), 32'd1);
      chk("t4_hold_gnt", 32'(wr_grant), 32'd0);
    end
    mem_cmd_ready = 1'b1;
    tick();
    chk("t4_gnt", 32'(wr_grant), 32'd1);
    chk("t4_vdrop", 32'(mem_cmd_valid), 32'd0);
    mem_cmd_ready = 1'b0;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;

    // Reset while a read burst is outstanding
    wait_valid("t6");
    chk("t6_addr", mem_cmd_addr, 32'h200);
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    chk("t6_rgnt", 32'(rd_grant), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(mem_cmd_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_addr", mem_cmd_addr, 32'h0);
    chk("t6_rst_we", 32'(mem_cmd_we), 32'd0);
    chk("t6_rst_widx", 32'(write_idx), 32'd0);
    chk("t6_rst_ridx", 32'(read_idx), 32'd2);
    tick();
    rst = 1'b0;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    tick();
    chk("t6_late_busy", 32'(busy), 32'd0);
    chk("t6_late_valid", 32'(mem_cmd_valid), 32'd0);
    rd_req = 1'b0;
    pulse_start();
    burst("t6_w0", 1'b1, 32'h000, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
